// File: rtl/pe_memory_bank.sv
// Simple dual-port word store for a processing element: one write port and one
// read port with independent addresses, plus a registered read-data output.
module pe_memory_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;
    logic              w_wr_en;

    // Storage has no reset so it maps onto block RAM; writes are still blocked while rst is low.
    assign w_wr_en = we & rst;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[wr_addr] <= data_in;
        end
    end

    // Non-blocking read of the array gives read-before-write on a same-address collision.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
        end else if (re) begin
            r_data_out <= r_mem[rd_addr];
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_pe_memory_bank.sv
// Directed scoreboard bench for pe_memory_bank: expected read data is queued when
// each access is driven and checked one cycle later against a behavioural model.
module tb_pe_memory_bank;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int LAST   = 2 ** ADDR_W - 1;

    typedef struct {
        logic              chk;
        logic [DATA_W-1:0] val;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model [int];
    exp_t              expQ [$];
    logic              holdKnown;
    logic [DATA_W-1:0] holdVal;

    pe_memory_bank #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .re      (re),
        .rd_addr (rd_addr),
        .wr_addr (wr_addr),
        .data_in (data_in),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] expVal);
        checks++;
        assert (data_out === expVal)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, data_out, expVal);
        end
    endtask

    // One clock of traffic: queue the expected output, update the model, clock, then check.
    task automatic applyStimulus(input logic inWe, input int inWa, input logic [DATA_W-1:0] inDin,
                                 input logic inRe, input int inRa, input string tag);
        exp_t item;
        we      = inWe;
        wr_addr = ADDR_W'(inWa);
        data_in = inDin;
        re      = inRe;
        rd_addr = ADDR_W'(inRa);
        if (inRe) begin
            holdKnown = model.exists(inRa);
            holdVal   = holdKnown ? model[inRa] : '0;
        end
        item.chk = holdKnown;
        item.val = holdVal;
        expQ.push_back(item);
        if (inWe) model[inWa] = inDin;
        @(posedge clk);
        #1;
        item = expQ.pop_front();
        if (item.chk) checkOutput(tag, item.val);
        we = 1'b0;
        re = 1'b0;
    endtask

    task automatic enterReset();
        rst = 1'b0;
        #1;
        holdKnown = 1'b1;
        holdVal   = '0;
        checkOutput("reset_immediate", '0);
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; re = 1'b0;
        rd_addr = '0; wr_addr = '0; data_in = '0;
        holdKnown = 1'b1;
        holdVal   = '0;
        #1;
        checkOutput("reset_state", '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(1'b1, 5, 16'h1234, 1'b0, 0, "wr5");
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, 5, "rd5");
        applyStimulus(1'b0, 0, 16'h0000, 1'b0, 0, "hold5_a");
        applyStimulus(1'b0, 0, 16'h0000, 1'b0, 0, "hold5_b");

        // Asynchronous reset between edges, then reads held off for three clocks.
        #2;
        enterReset();
        for (int i = 0; i < 3; i++) begin
            re = 1'b1;
            rd_addr = ADDR_W'(5);
            @(posedge clk);
            #1;
            checkOutput("reset_hold_rd", '0);
        end
        re = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 0, 16'h0000, 1'b0, 0, "post_reset_idle");
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, 5, "post_reset_rd5");

        applyStimulus(1'b1, 7, 16'h00AA, 1'b0, 0, "wr7");
        applyStimulus(1'b1, 7, 16'h0055, 1'b1, 7, "collide_old");
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, 7, "collide_new");

        applyStimulus(1'b1, 8, 16'h1357, 1'b1, 5, "diff_addr_rd5");
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, 8, "diff_addr_rd8");

        for (int a = 0; a < 16; a++)
            applyStimulus(1'b1, a, DATA_W'(a * 3), 1'b0, 0, "stream_wr");
        for (int a = 0; a < 16; a++)
            applyStimulus(1'b0, 0, 16'h0000, 1'b1, a, "stream_rd");

        applyStimulus(1'b1, LAST, 16'hFFFF, 1'b0, 0, "wr_last");
        applyStimulus(1'b1, 0, 16'h0001, 1'b0, 0, "wr_zero");
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, LAST, "rd_last");
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, 0, "rd_zero");
        applyStimulus(1'b1, 512, 16'h0A0A, 1'b1, LAST, "rd_last_again");
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, 512, "rd_mid");

        // Retention: contents survive reset and writes during reset are dropped.
        applyStimulus(1'b1, 9, 16'hBEEF, 1'b1, LAST, "wr9");
        #2;
        enterReset();
        we = 1'b1;
        wr_addr = ADDR_W'(9);
        data_in = 16'h1111;
        re = 1'b1;
        rd_addr = ADDR_W'(9);
        @(posedge clk);
        #1;
        checkOutput("retain_in_reset", '0);
        we = 1'b0;
        re = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, 9, "retain_rd9");

        // A read pending at the edge is cancelled by reset and stays cancelled after release.
        re = 1'b1;
        rd_addr = ADDR_W'(7);
        #2;
        enterReset();
        @(posedge clk);
        #1;
        checkOutput("midread_reset", '0);
        re = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 0, 16'h0000, 1'b0, 0, "midread_hold");
        applyStimulus(1'b0, 0, 16'h0000, 1'b1, 7, "midread_rd7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
